piso_stream_ser: RTL and testbench

Parametrised parallel-in/serial-out serializer, the successor to the 4-bit load/shift PISO.
- Accepts WIDTH-bit words over a valid/ready handshake into a one-entry holding buffer.
- Shifts each word out one bit per enabled clock, MSB-first or LSB-first, with per-bit valid and end-of-frame flags.
- The holding buffer lets consecutive words stream with no idle bit between them.
- Sits between a parallel producer (register file, FIFO) and a serial link or bit-bang transmitter.

---
 rtl/piso_pkg.sv | 9 +
 rtl/piso_stream_ser_if.sv | 10 +
 rtl/piso_hold_buf.sv | 23 ++
 rtl/piso_stream_ser.sv | 65 ++++++
 tb/tb_piso_stream_ser.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared constants, shifter state type and counter-width helper for piso_stream_ser
package piso_pkg;
  localparam logic ORDER_MSB_FIRST = 1'b0;
  localparam logic ORDER_LSB_FIRST = 1'b1;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} sh_state_t;
  function automatic int cnt_width(int w);
    return w > 2 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/piso_stream_ser_if.sv
// piso_stream_ser_if: parallel word handshake (s_valid/s_ready, s_data, s_lsb_first)
// master = producer side, slave = serializer side
interface piso_stream_ser_if #(parameter int WIDTH = 8);
  logic s_valid;
  logic s_ready;
  logic s_lsb_first;
  logic [WIDTH-1:0] s_data;
  modport master(output s_valid, s_data, s_lsb_first, input s_ready);
  modport slave(input s_valid, s_data, s_lsb_first, output s_ready);
endinterface

// File: rtl/piso_hold_buf.sv
// piso_hold_buf: one-entry valid/ready register slice
// ports: in_valid/in_ready/in_data push side, out_valid/out_data/out_pop drain side
module piso_hold_buf #(parameter int W = 9) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_pop
);
  // ready comes straight from the full flag, so push and pop never coincide
  assign in_ready = !out_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_pop) out_valid <= 1'b0;
endmodule

// File: rtl/piso_stream_ser.sv
// piso_stream_ser: WIDTH-bit word to serial stream, per-word MSB/LSB order, gapless back-to-back frames
// ports: clk, rst_n (async active-low), s (word handshake, slave), ser_en (downstream advance),
//        ser_out/ser_valid/ser_last (serial bit + flags), busy (shifter or hold buffer occupied)
module piso_stream_ser import piso_pkg::*; #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  piso_stream_ser_if.slave   s,
  input  logic               ser_en,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               ser_last,
  output logic               busy
);
  localparam int CW = cnt_width(WIDTH);
  logic             hold_full;
  logic [WIDTH:0]   hold_word;
  logic             hold_lsb;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] sh_data;
  logic             sh_lsb;
  logic [CW-1:0]    bit_cnt;
  sh_state_t        state;
  logic             sh_active;
  logic             at_end;
  logic             pop;
  piso_hold_buf #(.W(WIDTH + 1)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s.s_valid),
    .in_ready (s.s_ready),
    .in_data  ({s.s_lsb_first, s.s_data}),
    .out_valid(hold_full),
    .out_data (hold_word),
    .out_pop  (pop)
  );
  assign hold_lsb  = hold_word[WIDTH];
  assign hold_data = hold_word[WIDTH-1:0];
  assign sh_active = state == SHIFT;
  assign at_end    = sh_active && bit_cnt == CW'(WIDTH - 1);
  // reload on idle regardless of ser_en, or on the final enabled bit so frames abut
  assign pop       = hold_full && (!sh_active || (ser_en && at_end));
  assign ser_valid = sh_active;
  assign ser_last  = at_end;
  assign busy      = sh_active || hold_full;
  assign ser_out   = sh_active ? (sh_lsb == ORDER_LSB_FIRST ? sh_data[0] : sh_data[WIDTH-1]) : IDLE_LEVEL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      sh_data <= '0;
      sh_lsb  <= 1'b0;
      bit_cnt <= '0;
    end else if (pop) begin
      state   <= SHIFT;
      sh_data <= hold_data;
      sh_lsb  <= hold_lsb;
      bit_cnt <= '0;
    end else if (sh_active && ser_en) begin
      state   <= at_end ? IDLE : SHIFT;
      sh_data <= sh_lsb == ORDER_LSB_FIRST ? sh_data >> 1 : sh_data << 1;
      bit_cnt <= at_end ? '0 : bit_cnt + 1'b1;
    end
endmodule

// File: tb/tb_piso_stream_ser.sv
// tb_piso_stream_ser: bit-queue reference model with per-cycle compare, plus directed literal checks
module tb_piso_stream_ser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_en = 1'b1;
  logic ser_out, ser_valid, ser_last, busy;
  logic ser_en4 = 1'b1;
  logic ser_out4, ser_valid4, ser_last4, busy4;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;

  piso_stream_ser_if #(.WIDTH(8)) bus ();
  piso_stream_ser_if #(.WIDTH(4)) bus4 ();

  piso_stream_ser #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave), .ser_en(ser_en),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy)
  );
  piso_stream_ser #(.WIDTH(4), .IDLE_LEVEL(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .s(bus4.slave), .ser_en(ser_en4),
    .ser_out(ser_out4), .ser_valid(ser_valid4), .ser_last(ser_last4), .busy(busy4)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: the pending word plus the queue of bits still to leave the current frame
  bit   mq[$];
  logic m_full = 1'b0;
  logic m_lsb = 1'b0;
  logic [7:0] m_word = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mq.delete();
      m_full = 1'b0;
    end else begin
      logic acc;
      acc = bus.s_valid && !m_full;
      if (mq.size() > 0 && ser_en) void'(mq.pop_front());
      if (m_full && mq.size() == 0) begin
        for (int i = 0; i < 8; i++) mq.push_back(m_lsb ? m_word[i] : m_word[7-i]);
        m_full = 1'b0;
      end
      if (acc) begin
        m_full = 1'b1;
        m_word = bus.s_data;
        m_lsb  = bus.s_lsb_first;
      end
    end

  always @(negedge clk) begin
    logic act, exp_out;
    act = mq.size() > 0;
    exp_out = 1'b0;
    if (act) exp_out = mq[0];
    chk("s_ready", 32'(bus.s_ready), 32'(!m_full));
    chk("busy", 32'(busy), 32'(act || m_full));
    chk("ser_valid", 32'(ser_valid), 32'(act));
    chk("ser_last", 32'(ser_last), 32'(act && mq.size() == 1));
    chk("ser_out", 32'(ser_out), 32'(exp_out));
  end

  // capture of DUT serial traffic for literal frame checks
  logic [15:0] cap_word, cap_last;
  int cap_n, run, max_run;
  task automatic clr();
    cap_word = '0; cap_last = '0; cap_n = 0; run = 0; max_run = 0;
  endtask
  task automatic tick();
    if (ser_valid && ser_en) begin
      cap_word = {cap_word[14:0], ser_out};
      cap_last = {cap_last[14:0], ser_last};
      cap_n++;
    end
    run = ser_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [7:0] d, logic l);
    logic a;
    int n;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_lsb_first = l;
    n = 0;
    do begin
      a = bus.s_ready;
      tick();
      n++;
    end while (!a && n < 50);
    if (!a) chk("send_timeout", 32'd1, 32'd0);
    bus.s_valid = 1'b0;
    bus.s_data = 8'($urandom);
  endtask

  initial begin
    logic [5:0] e4_v, e4_o, e4_l;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_lsb_first = 1'b0;
    bus4.s_valid = 1'b0; bus4.s_data = '0; bus4.s_lsb_first = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #3;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ser_valid", 32'(ser_valid), 32'd0);
    chk("rst_ser_last", 32'(ser_last), 32'd0);
    chk("rst_ser_out", 32'(ser_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WIDTH=4, IDLE_LEVEL=1: legacy MSB-first order 1,0,1,1 then idle
    e4_v = 6'b011110; e4_o = 6'b110111; e4_l = 6'b000010;
    bus4.s_valid = 1'b1; bus4.s_data = 4'b1011; bus4.s_lsb_first = 1'b0;
    @(posedge clk); #1;
    bus4.s_valid = 1'b0; bus4.s_data = 4'b0110;
    for (int i = 5; i >= 0; i--) begin
      chk("w4_valid", 32'(ser_valid4), 32'(e4_v[i]));
      chk("w4_out", 32'(ser_out4), 32'(e4_o[i]));
      chk("w4_last", 32'(ser_last4), 32'(e4_l[i]));
      @(posedge clk); #1;
    end

    clr();
    send(8'hB4, 1'b0);
    repeat (12) tick();
    chk("msb_n", cap_n, 8);
    chk("msb_bits", 32'(cap_word[7:0]), 32'hB4);
    chk("msb_last", 32'(cap_last[7:0]), 32'h01);
    chk("msb_valid_len", max_run, 8);

    clr();
    send(8'hB4, 1'b1);
    repeat (12) tick();
    chk("lsb_n", cap_n, 8);
    chk("lsb_bits", 32'(cap_word[7:0]), 32'h2D);

    clr();
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b0);
    repeat (20) tick();
    chk("b2b_n", cap_n, 16);
    chk("b2b_bits", 32'(cap_word), 32'hA53C);
    chk("b2b_last", 32'(cap_last), 32'h0101);
    chk("b2b_valid_len", max_run, 16);

    clr();
    send(8'hFF, 1'b0);
    repeat (4) tick();
    ser_en = 1'b0;
    repeat (3) begin
      chk("stall_valid", 32'(ser_valid), 32'd1);
      chk("stall_out", 32'(ser_out), 32'd1);
      tick();
    end
    ser_en = 1'b1;
    repeat (10) tick();
    chk("stall_n", cap_n, 8);
    chk("stall_bits", 32'(cap_word[7:0]), 32'hFF);
    chk("stall_valid_len", max_run, 11);

    send(8'($urandom), 1'($urandom));
    send(8'($urandom), 1'($urandom));
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_held", 32'(bus.s_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ser_valid", 32'(ser_valid), 32'd0);
    chk("arst_ser_last", 32'(ser_last), 32'd0);
    chk("arst_ser_out", 32'(ser_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_s_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clr();
    repeat (12) tick();
    chk("post_rst_bits", cap_n, 0);
    chk("post_rst_valid", max_run, 0);
    chk("post_rst_ready", 32'(bus.s_ready), 32'd1);

    repeat (400) begin
      bus.s_valid = 1'($urandom);
      bus.s_data = 8'($urandom);
      bus.s_lsb_first = 1'($urandom);
      ser_en = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.s_valid = 1'b0;
    ser_en = 1'b1;
    repeat (24) tick();
    chk("drain_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
